// File: rtl/bcd_down_timer.sv
// bcd_down_timer: MM:SS BCD countdown timer, {min1, min0, sec1, sec0}.
// Preset via load (digits clamped to valid BCD time), counts down at TICK_HZ
// derived from CLK_HZ, and flags expiry on time_out.
// Optional build macro: AUTO_RELOAD_EN. When defined, the last accepted preset
// is kept in a shadow register and reloaded on expiry, with a one-cycle
// time_out pulse.
module bcd_down_timer #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        init_rst,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] times,
    output logic [15:0] time_out,
    output logic        running
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        r_state, w_state_nx;
    logic [15:0]   r_times, w_times_nx;
    logic [PW-1:0] r_presc, w_presc_nx;
    logic [15:0]   r_time_out;
    logic [15:0]   w_dec;
    logic [15:0]   w_clamped;
    logic          w_reload;
`ifdef AUTO_RELOAD_EN
    logic [15:0]   r_shadow, w_shadow_nx;
`endif

    // Force each digit into its legal range: tens <= 5, units <= 9.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] p);
        logic [3:0] m1, m0, s1, s0;
        m1 = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
        m0 = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
        s1 = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
        s0 = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
        return {m1, m0, s1, s0};
    endfunction

    // One-second BCD decrement with borrow chain; saturates at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (t != 16'h0000) begin
            if (s0 != 4'd0) begin
                s0 = s0 - 4'd1;
            end else begin
                s0 = 4'd9;
                if (s1 != 4'd0) begin
                    s1 = s1 - 4'd1;
                end else begin
                    s1 = 4'd5;
                    if (m0 != 4'd0) begin
                        m0 = m0 - 4'd1;
                    end else begin
                        m0 = 4'd9;
                        m1 = m1 - 4'd1;
                    end
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    assign w_dec     = bcd_dec(r_times);
    assign w_clamped = clamp_bcd(preset);

    // Next-state logic; branch order encodes rst > load > pause > start > tick.
    always_comb begin
        w_state_nx  = r_state;
        w_times_nx  = r_times;
        w_presc_nx  = r_presc;
        w_reload    = 1'b0;
`ifdef AUTO_RELOAD_EN
        w_shadow_nx = r_shadow;
`endif
        if (rst) begin
            w_state_nx  = IDLE;
            w_times_nx  = 16'h0000;
            w_presc_nx  = '0;
`ifdef AUTO_RELOAD_EN
            w_shadow_nx = 16'h0000;
`endif
        end else if (load && r_state != RUN) begin
            w_state_nx  = IDLE;
            w_times_nx  = w_clamped;
            w_presc_nx  = '0;
`ifdef AUTO_RELOAD_EN
            w_shadow_nx = w_clamped;
`endif
        end else if (pause && (r_state == RUN || r_state == PAUSE)) begin
            // prescaler held so a resume keeps the partial second
            w_state_nx = PAUSE;
        end else if (start && r_state == IDLE) begin
            w_state_nx = (r_times != 16'h0000) ? RUN : DONE;
            w_presc_nx = '0;
        end else if (start && r_state == PAUSE) begin
            w_state_nx = RUN;
        end else if (r_state == RUN) begin
            if (r_presc == P_LAST) begin
                w_presc_nx = '0;
                w_times_nx = w_dec;
                if (w_dec == 16'h0000) begin
`ifdef AUTO_RELOAD_EN
                    if (r_shadow != 16'h0000) begin
                        w_times_nx = r_shadow;
                        w_reload   = 1'b1;
                    end else begin
                        w_state_nx = DONE;
                    end
`else
                    w_state_nx = DONE;
`endif
                end
            end else begin
                w_presc_nx = r_presc + 1'b1;
            end
        end
    end

    // State registers; time_out tracks the next state so it lines up with DONE.
    always_ff @(posedge clk or negedge init_rst) begin
        if (!init_rst) begin
            r_state    <= IDLE;
            r_times    <= 16'h0000;
            r_presc    <= '0;
            r_time_out <= 16'h0000;
        end else begin
            r_state    <= w_state_nx;
            r_times    <= w_times_nx;
            r_presc    <= w_presc_nx;
            r_time_out <= {16{(w_state_nx == DONE) || w_reload}};
        end
    end

`ifdef AUTO_RELOAD_EN
    // Shadow copy of the last accepted preset for reload on expiry.
    always_ff @(posedge clk or negedge init_rst) begin
        if (!init_rst) r_shadow <= 16'h0000;
        else           r_shadow <= w_shadow_nx;
    end
`endif

    assign times    = r_times;
    assign time_out = r_time_out;
    assign running  = (r_state == RUN);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer at CLK_HZ=4, TICK_HZ=1 (one tick every 4 clocks).
// Per-cycle vector table; expected values queued at drive time and checked
// by a separate process after each rising edge.
module tb_bcd_down_timer;

    logic        clk = 1'b0;
    logic        init_rst, rst, load, start, pause;
    logic [15:0] preset;
    logic [15:0] times, time_out;
    logic        running;

    int n_vec = 0;
    int n_err = 0;

    bcd_down_timer #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk(clk), .init_rst(init_rst), .rst(rst), .load(load),
        .preset(preset), .start(start), .pause(pause),
        .times(times), .time_out(time_out), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, load;
        logic [15:0] preset;
        logic        start, pause;
        logic [15:0] times;
        logic        to;
        logic        run;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] times;
        logic        to;
        logic        run;
    } exp_t;

    vec_t vt[$];
    exp_t exp_q[$];
    exp_t e_chk;

    task automatic add(input logic r, input logic l, input logic [15:0] p,
                       input logic s, input logic pa,
                       input logic [15:0] t, input logic to, input logic run);
        vec_t v;
        v.rst = r; v.load = l; v.preset = p; v.start = s; v.pause = pa;
        v.times = t; v.to = to; v.run = run;
        vt.push_back(v);
    endtask

    task automatic nops(input int n, input logic [15:0] t, input logic to, input logic run);
        for (int k = 0; k < n; k++) add(0, 0, 16'h0000, 0, 0, t, to, run);
    endtask

    task automatic chk(input string name, input logic [15:0] t, input logic to, input logic run);
        n_vec++;
        if (times !== t || time_out !== {16{to}} || running !== run) begin
            n_err++;
            $display("FAIL %s: times=%h time_out=%h running=%b, expected times=%h time_out=%h running=%b",
                     name, times, time_out, running, t, {16{to}}, run);
        end
    endtask

    // Scoreboard: pop and compare one expectation after every rising edge.
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e_chk = exp_q.pop_front();
            n_vec++;
            if (times !== e_chk.times || time_out !== {16{e_chk.to}} || running !== e_chk.run) begin
                n_err++;
                $display("FAIL vec%0d: times=%h time_out=%h running=%b, expected times=%h time_out=%h running=%b",
                         e_chk.idx, times, time_out, running, e_chk.times, {16{e_chk.to}}, e_chk.run);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        init_rst = 1'b0; rst = 0; load = 0; start = 0; pause = 0; preset = 16'h0000;

        // borrow through sec1 and min0
        add(0,1,16'h0102,0,0, 16'h0102,0,0);
        add(0,0,16'h0000,1,0, 16'h0102,0,1);
        nops(3,16'h0102,0,1); nops(1,16'h0101,0,1);
        nops(3,16'h0101,0,1); nops(1,16'h0100,0,1);
        nops(3,16'h0100,0,1); nops(1,16'h0059,0,1);
        nops(3,16'h0059,0,1); nops(1,16'h0058,0,1);
        add(1,0,16'h0000,0,0, 16'h0000,0,0);
        // expiry, DONE hold, start ignored, load leaves DONE
        add(0,1,16'h0001,0,0, 16'h0001,0,0);
        add(0,0,16'h0000,1,0, 16'h0001,0,1);
        nops(3,16'h0001,0,1); nops(1,16'h0000,1,0);
        nops(2,16'h0000,1,0);
        add(0,0,16'h0000,1,0, 16'h0000,1,0);
        add(0,0,16'h0000,0,1, 16'h0000,1,0);
        add(0,1,16'h0005,0,0, 16'h0005,0,0);
        // load beats start; load ignored in RUN
        add(0,1,16'h0030,1,0, 16'h0030,0,0);
        nops(1,16'h0030,0,0);
        add(0,0,16'h0000,1,0, 16'h0030,0,1);
        add(0,1,16'h0099,0,0, 16'h0030,0,1);
        nops(2,16'h0030,0,1); nops(1,16'h0029,0,1);
        // pause beats start in RUN and PAUSE; load honoured in PAUSE
        add(0,0,16'h0000,1,1, 16'h0029,0,0);
        add(0,0,16'h0000,1,1, 16'h0029,0,0);
        add(0,1,16'h0100,0,0, 16'h0100,0,0);
        nops(1,16'h0100,0,0);
        // clamping, start from zero goes straight to DONE
        add(0,1,16'hFAFA,0,0, 16'h5959,0,0);
        add(0,1,16'h6A7B,0,0, 16'h5959,0,0);
        add(0,1,16'h3C48,0,0, 16'h3948,0,0);
        add(1,0,16'h0000,0,0, 16'h0000,0,0);
        add(0,0,16'h0000,1,0, 16'h0000,1,0);
        nops(1,16'h0000,1,0);
        add(1,0,16'h0000,0,0, 16'h0000,0,0);
        // pause keeps the partial second across resume
        add(0,1,16'h0010,0,0, 16'h0010,0,0);
        add(0,0,16'h0000,1,0, 16'h0010,0,1);
        nops(2,16'h0010,0,1);
        add(0,0,16'h0000,0,1, 16'h0010,0,0);
        nops(10,16'h0010,0,0);
        add(0,0,16'h0000,1,0, 16'h0010,0,1);
        nops(1,16'h0010,0,1); nops(1,16'h0009,0,1);
        nops(3,16'h0009,0,1); nops(1,16'h0008,0,1);
        add(1,0,16'h0000,0,0, 16'h0000,0,0);
        // expiry from 0002: reload or DONE depending on build
        add(0,1,16'h0002,0,0, 16'h0002,0,0);
        add(0,0,16'h0000,1,0, 16'h0002,0,1);
        nops(3,16'h0002,0,1); nops(1,16'h0001,0,1);
        nops(3,16'h0001,0,1);
`ifdef AUTO_RELOAD_EN
        nops(1,16'h0002,1,1);
        nops(2,16'h0002,0,1);
`else
        nops(1,16'h0000,1,0);
        nops(2,16'h0000,1,0);
`endif
        add(1,0,16'h0000,0,0, 16'h0000,0,0);
        nops(2,16'h0000,0,0);

        #3;
        chk("reset_state", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        init_rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            rst = vt[i].rst; load = vt[i].load; preset = vt[i].preset;
            start = vt[i].start; pause = vt[i].pause;
            exp_q.push_back('{i, vt[i].times, vt[i].to, vt[i].run});
        end
        @(negedge clk);
        rst = 0; load = 0; start = 0; pause = 0; preset = 16'h0000;
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        // asynchronous clear mid-count, no activity after release
        load = 1; preset = 16'h0005;
        @(negedge clk); load = 0; start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        chk("mid_count_running", 16'h0005, 1'b0, 1'b1);
        #2 init_rst = 1'b0;
        #1 chk("async_clear", 16'h0000, 1'b0, 1'b0);
        @(negedge clk); init_rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("after_release_idle", 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
